// File: rtl/demux_4_6_reg.sv
// demux_4_6_reg: registered 1-to-6 nibble distributor.
// Writes 4-bit values from a valid/ready producer into six slot registers
// (q0..q5). The target slot is the auto-increment pointer or an explicit
// address. Occupancy is tracked with a per-slot written mask.
module demux_4_6_reg #(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       addr_en,
    input  logic [2:0] in_addr,
    input  logic       clr,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic [3:0] q4,
    output logic [3:0] q5,
    output logic [2:0] ptr,
    output logic [2:0] count,
    output logic       full,
    output logic       err
);

    localparam logic [2:0] LAST_SLOT = 3'd5;

    logic [3:0] slot_reg [6];
    logic [5:0] mask_reg;
    logic [2:0] ptr_reg;
    logic       err_reg;

    logic [2:0] target;
    logic [2:0] ptr_next;
    logic [2:0] count_next;
    logic       accept;
    logic       legal;
    logic [5:0] wr_en;

    // Without wrap the block stalls once every slot holds data; clr always
    // blocks the concurrent transfer so the clear wins.
    assign full     = &mask_reg;
    assign in_ready = ~clr & (WRAP ? 1'b1 : ~full);
    assign accept   = in_valid & in_ready;

    // The pointer never leaves 0..5, so only an explicit address can be illegal.
    assign target   = addr_en ? in_addr : ptr_reg;
    assign legal    = (target <= LAST_SLOT);
    assign ptr_next = (target == LAST_SLOT) ? 3'd0 : target + 3'd1;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_slot
            assign wr_en[gi] = accept & legal & (target == 3'(gi));

            // Slot storage and its written flag; clr wipes both.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= 4'd0;
                    mask_reg[gi] <= 1'b0;
                end else if (clr) begin
                    slot_reg[gi] <= 4'd0;
                    mask_reg[gi] <= 1'b0;
                end else if (wr_en[gi]) begin
                    slot_reg[gi] <= in_data;
                    mask_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Pointer follows the last legal write; err pulses for one cycle per illegal accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 3'd0;
            err_reg <= 1'b0;
        end else if (clr) begin
            ptr_reg <= 3'd0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept & ~legal;
            if (accept && legal) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    // Occupancy is the number of written slots, so rewrites do not change it.
    always_comb begin
        count_next = 3'd0;
        for (int i = 0; i < 6; i++) begin
            count_next = count_next + {2'b00, mask_reg[i]};
        end
    end

    assign q0    = slot_reg[0];
    assign q1    = slot_reg[1];
    assign q2    = slot_reg[2];
    assign q3    = slot_reg[3];
    assign q4    = slot_reg[4];
    assign q5    = slot_reg[5];
    assign ptr   = ptr_reg;
    assign count = count_next;
    assign err   = err_reg;

endmodule

// File: tb/tb_demux_4_6_reg.sv
// Testbench for demux_4_6_reg: one instance per WRAP setting driven by shared
// stimulus. The driver pushes expected outputs into a scoreboard queue; a
// separate monitor pops and compares against both instances.
module tb_demux_4_6_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       addr_en;
    logic [2:0] in_addr;
    logic       clr;

    // Index 0: WRAP=0 instance, index 1: WRAP=1 instance.
    logic [3:0] dq     [2][6];
    logic [2:0] dptr   [2];
    logic [2:0] dcount [2];
    logic       dfull  [2];
    logic       derr   [2];
    logic       drdy   [2];

    always #5 clk = ~clk;

    demux_4_6_reg #(.WRAP(1'b0)) u_nowrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[0]),
        .in_data(in_data), .addr_en(addr_en), .in_addr(in_addr), .clr(clr),
        .q0(dq[0][0]), .q1(dq[0][1]), .q2(dq[0][2]), .q3(dq[0][3]),
        .q4(dq[0][4]), .q5(dq[0][5]),
        .ptr(dptr[0]), .count(dcount[0]), .full(dfull[0]), .err(derr[0])
    );

    demux_4_6_reg #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[1]),
        .in_data(in_data), .addr_en(addr_en), .in_addr(in_addr), .clr(clr),
        .q0(dq[1][0]), .q1(dq[1][1]), .q2(dq[1][2]), .q3(dq[1][3]),
        .q4(dq[1][4]), .q5(dq[1][5]),
        .ptr(dptr[1]), .count(dcount[1]), .full(dfull[1]), .err(derr[1])
    );

    typedef struct packed {
        logic [1:0][5:0][3:0] q;
        logic [1:0][2:0]      ptr;
        logic [1:0][2:0]      cnt;
        logic [1:0]           full;
        logic [1:0]           err;
        logic [1:0]           rdy;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    event  chk_now;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference state per instance
    logic [3:0] mq    [2][6];
    logic [5:0] mmask [2];
    logic [2:0] mptr  [2];
    logic       merr  [2];

    function automatic void mreset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 6; i++) mq[w][i] = 4'd0;
            mmask[w] = 6'd0;
            mptr[w]  = 3'd0;
            merr[w]  = 1'b0;
        end
    endfunction

    function automatic logic mready(int w, logic c);
        if (c) return 1'b0;
        if (w == 1) return 1'b1;
        return ~(&mmask[w]);
    endfunction

    // Apply one clock edge with the given inputs to the reference.
    function automatic void mupdate(logic v, logic [3:0] d, logic aen, logic [2:0] a, logic c);
        int tgt;
        logic rdy;
        for (int w = 0; w < 2; w++) begin
            rdy = mready(w, c);
            if (c) begin
                for (int i = 0; i < 6; i++) mq[w][i] = 4'd0;
                mmask[w] = 6'd0;
                mptr[w]  = 3'd0;
                merr[w]  = 1'b0;
            end else begin
                merr[w] = 1'b0;
                if (v && rdy) begin
                    tgt = aen ? int'(a) : int'(mptr[w]);
                    if (tgt > 5) begin
                        merr[w] = 1'b1;
                    end else begin
                        mq[w][tgt]    = d;
                        mmask[w][tgt] = 1'b1;
                        mptr[w]       = (tgt == 5) ? 3'd0 : 3'(tgt + 1);
                    end
                end
            end
        end
    endfunction

    function automatic void push_exp(string nm);
        exp_t e;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 6; i++) e.q[w][i] = mq[w][i];
            e.ptr[w]  = mptr[w];
            e.cnt[w]  = 3'($countones(mmask[w]));
            e.full[w] = &mmask[w];
            e.err[w]  = merr[w];
            e.rdy[w]  = mready(w, clr);
        end
        sb.push_back(e);
        sb_name.push_back(nm);
    endfunction

    function automatic void chk(string nm, string fld, int w, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s (WRAP=%0d): got %0h expected %0h", nm, fld, w, act, exp);
        end
    endfunction

    // Monitor: compare every expected record against the live outputs.
    initial begin : monitor
        exp_t  e;
        string nm;
        logic [23:0] qa;
        int txn;
        txn = 0;
        forever begin
            @(negedge clk or chk_now);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                for (int w = 0; w < 2; w++) begin
                    for (int i = 0; i < 6; i++) qa[i*4 +: 4] = dq[w][i];
                    chk(nm, "q", w, {8'd0, qa}, {8'd0, e.q[w]});
                    chk(nm, "ptr", w, {29'd0, dptr[w]}, {29'd0, e.ptr[w]});
                    chk(nm, "count", w, {29'd0, dcount[w]}, {29'd0, e.cnt[w]});
                    chk(nm, "full", w, {31'd0, dfull[w]}, {31'd0, e.full[w]});
                    chk(nm, "err", w, {31'd0, derr[w]}, {31'd0, e.err[w]});
                    chk(nm, "in_ready", w, {31'd0, drdy[w]}, {31'd0, e.rdy[w]});
                end
                $display("txn %0d %-12s wrap1 q=%h%h%h%h%h%h ptr=%0d cnt=%0d | wrap0 ptr=%0d cnt=%0d rdy=%0b",
                         txn, nm, dq[1][5], dq[1][4], dq[1][3], dq[1][2], dq[1][1], dq[1][0],
                         dptr[1], dcount[1], dptr[0], dcount[0], drdy[0]);
                txn++;
            end
        end
    end

    // One cycle: drive inputs, record expectation for the pre-edge state, clock the reference.
    task automatic step(string nm, logic v, logic [3:0] d, logic aen, logic [2:0] a, logic c);
        in_valid = v;
        in_data  = d;
        addr_en  = aen;
        in_addr  = a;
        clr      = c;
        push_exp(nm);
        @(posedge clk);
        mupdate(v, d, aen, a, c);
        #1;
    endtask

    task automatic idle(string nm);
        step(nm, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        addr_en  = 1'b0;
        in_addr  = 3'd0;
        clr      = 1'b0;
        mreset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("reset");

        // Auto fill 1..6
        for (int i = 1; i <= 6; i++) step("autofill", 1'b1, 4'(i), 1'b0, 3'd0, 1'b0);
        idle("filled");

        // Wrap overwrite vs stall
        step("wrapwrite", 1'b1, 4'hA, 1'b0, 3'd0, 1'b0);
        idle("after_wrap");
        // Explicit writes are also blocked when stalled
        step("full_expl", 1'b1, 4'hB, 1'b1, 3'd2, 1'b0);
        idle("after_expl");

        // Clear, then explicit write repositions pointer
        step("clr", 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        step("expl3", 1'b1, 4'h9, 1'b1, 3'd3, 1'b0);
        step("auto7", 1'b1, 4'h7, 1'b0, 3'd0, 1'b0);
        idle("after_auto7");

        // Illegal addresses: err pulse, state unchanged
        step("ill6", 1'b1, 4'hF, 1'b1, 3'd6, 1'b0);
        idle("err_pulse");
        idle("err_gone");
        step("ill7", 1'b1, 4'hE, 1'b1, 3'd7, 1'b0);
        step("auto3", 1'b1, 4'h3, 1'b0, 3'd0, 1'b0);
        idle("after_auto3");

        // Explicit write to the last slot wraps the pointer
        step("expl5", 1'b1, 4'hC, 1'b1, 3'd5, 1'b0);
        idle("ptr_wrap");

        // Clear with concurrent valid: data dropped
        step("clr2", 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        step("fill_a", 1'b1, 4'h1, 1'b0, 3'd0, 1'b0);
        step("fill_b", 1'b1, 4'h2, 1'b0, 3'd0, 1'b0);
        step("fill_c", 1'b1, 4'h3, 1'b0, 3'd0, 1'b0);
        step("clr_valid", 1'b1, 4'h5, 1'b0, 3'd0, 1'b1);
        idle("after_clr");

        // Asynchronous reset between edges while a write is presented
        step("pre_rst_a", 1'b1, 4'h4, 1'b0, 3'd0, 1'b0);
        step("pre_rst_b", 1'b1, 4'h6, 1'b1, 3'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h8;
        addr_en  = 1'b0;
        in_addr  = 3'd0;
        clr      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mreset();
        push_exp("async_rst");
        -> chk_now;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle("post_rst");
        step("post_write", 1'b1, 4'hD, 1'b0, 3'd0, 1'b0);
        idle("final");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
